// File: rtl/vinsn_issue_queue.sv
// Issue queue between scalar issue and the vector core: buffers instructions with their
// id, rs1 value and vl/vtype context, and throttles hand-off on outstanding vector work.
module vinsn_issue_queue #(
   parameter int unsigned Depth          = 4,
   parameter int unsigned MaxOutstanding = 8,
   parameter int unsigned IdWidth        = 8,
   parameter int unsigned XLen           = 32,
   parameter int unsigned CtxWidth       = 16,
   localparam int unsigned PtrW          = $clog2(Depth),
   localparam int unsigned OccW          = $clog2(Depth) + 1,
   localparam int unsigned OutW          = $clog2(MaxOutstanding) + 1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                valid_i,
   output logic                ready_o,
   input  logic [31:0]         insn_i,
   input  logic [IdWidth-1:0]  insn_id_i,
   input  logic [XLen-1:0]     scalar_reg_i,
   input  logic [CtxWidth-1:0] vec_context_i,
   input  logic                flush_i,
   output logic                vec_valid_o,
   input  logic                vec_ready_i,
   output logic [31:0]         vec_insn_o,
   output logic [IdWidth-1:0]  vec_insn_id_o,
   output logic [XLen-1:0]     vec_scalar_reg_o,
   output logic [CtxWidth-1:0] vec_context_o,
   input  logic                vec_done_i,
   output logic [OccW-1:0]     occupancy_o,
   output logic [OutW-1:0]     outstanding_o,
   output logic                underflow_o
);

   localparam logic [OccW-1:0] DEPTH_C   = OccW'(Depth);
   localparam logic [OutW-1:0] MAX_OUT_C = OutW'(MaxOutstanding);

   typedef struct packed {
      logic [31:0]         insn;
      logic [IdWidth-1:0]  id;
      logic [XLen-1:0]     scalar;
      logic [CtxWidth-1:0] ctx;
   } entry_t;

   entry_t          mem_q [Depth];
   entry_t          mem_d [Depth];
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [OccW-1:0] occ_q, occ_d;
   logic [OutW-1:0] out_q, out_d;
   logic            under_q, under_d;
   logic            push_s;
   logic            pop_s;

   // Handshakes depend only on state and flush, never on the consumer's ready.
   assign ready_o     = (occ_q < DEPTH_C) & ~flush_i;
   assign vec_valid_o = (occ_q != {OccW{1'b0}}) & (out_q < MAX_OUT_C) & ~flush_i;
   assign push_s      = valid_i & ready_o;
   assign pop_s       = vec_valid_o & vec_ready_i;

   assign vec_insn_o       = mem_q[rd_ptr_q].insn;
   assign vec_insn_id_o    = mem_q[rd_ptr_q].id;
   assign vec_scalar_reg_o = mem_q[rd_ptr_q].scalar;
   assign vec_context_o    = mem_q[rd_ptr_q].ctx;
   assign occupancy_o      = occ_q;
   assign outstanding_o    = out_q;
   assign underflow_o      = under_q;

   // Next-state for storage, pointers and occupancy.
   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      occ_d    = occ_q;
      if (flush_i) begin
         rd_ptr_d = {PtrW{1'b0}};
         wr_ptr_d = {PtrW{1'b0}};
         occ_d    = {OccW{1'b0}};
      end else begin
         if (push_s) begin
            mem_d[wr_ptr_q] = '{insn: insn_i, id: insn_id_i, scalar: scalar_reg_i,
                                ctx: vec_context_i};
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({push_s, pop_s})
            2'b10:   occ_d = occ_q + OccW'(1);
            2'b01:   occ_d = occ_q - OccW'(1);
            default: occ_d = occ_q;
         endcase
      end
   end

   // Outstanding count survives flush; a done with nothing outstanding is flagged, not counted.
   always_comb begin
      out_d   = out_q;
      under_d = under_q;
      case ({pop_s, vec_done_i})
         2'b10: out_d = out_q + OutW'(1);
         2'b01: begin
            if (out_q == {OutW{1'b0}}) begin
               under_d = 1'b1;
            end else begin
               out_d = out_q - OutW'(1);
            end
         end
         default: out_d = out_q;
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mem_q    <= '{default: '0};
         rd_ptr_q <= {PtrW{1'b0}};
         wr_ptr_q <= {PtrW{1'b0}};
         occ_q    <= {OccW{1'b0}};
         out_q    <= {OutW{1'b0}};
         under_q  <= 1'b0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         occ_q    <= occ_d;
         out_q    <= out_d;
         under_q  <= under_d;
      end
   end

endmodule

// File: tb/tb_vinsn_issue_queue.sv
// Self-checking bench for vinsn_issue_queue: directed scenarios plus random traffic,
// all checked against a queue-based reference model.
module tb_vinsn_issue_queue;
   localparam int DEPTH = 4;
   localparam int MAXO  = 8;
   localparam int IDW   = 8;
   localparam int XL    = 32;
   localparam int CW    = 16;

   logic           clk_i = 1'b0;
   logic           rst_i, valid_i, ready_o, flush_i, vec_valid_o, vec_ready_i, vec_done_i;
   logic [31:0]    insn_i, vec_insn_o;
   logic [IDW-1:0] insn_id_i, vec_insn_id_o;
   logic [XL-1:0]  scalar_reg_i, vec_scalar_reg_o;
   logic [CW-1:0]  vec_context_i, vec_context_o;
   logic [2:0]     occupancy_o;
   logic [3:0]     outstanding_o;
   logic           underflow_o;

   vinsn_issue_queue #(.Depth(DEPTH), .MaxOutstanding(MAXO), .IdWidth(IDW), .XLen(XL),
                       .CtxWidth(CW)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
      .insn_i(insn_i), .insn_id_i(insn_id_i), .scalar_reg_i(scalar_reg_i),
      .vec_context_i(vec_context_i), .flush_i(flush_i), .vec_valid_o(vec_valid_o),
      .vec_ready_i(vec_ready_i), .vec_insn_o(vec_insn_o), .vec_insn_id_o(vec_insn_id_o),
      .vec_scalar_reg_o(vec_scalar_reg_o), .vec_context_o(vec_context_o),
      .vec_done_i(vec_done_i), .occupancy_o(occupancy_o), .outstanding_o(outstanding_o),
      .underflow_o(underflow_o));

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0]    insn;
      logic [IDW-1:0] id;
      logic [XL-1:0]  sc;
      logic [CW-1:0]  ctx;
   } ent_t;

   ent_t           mq[$];
   int             m_out   = 0;
   bit             m_under = 0;
   int             n_checks = 0;
   int             n_fail   = 0;
   logic [IDW-1:0] next_id  = '0;

   function automatic bit m_ready();
      return (mq.size() < DEPTH) && !flush_i;
   endfunction

   function automatic bit m_vvalid();
      return (mq.size() != 0) && (m_out < MAXO) && !flush_i;
   endfunction

   task automatic idle();
      rst_i = 1'b0; valid_i = 1'b0; flush_i = 1'b0; vec_ready_i = 1'b0; vec_done_i = 1'b0;
   endtask

   task automatic new_payload();
      insn_i        = $urandom;
      insn_id_i     = next_id;
      scalar_reg_i  = $urandom;
      vec_context_i = 16'($urandom);
      next_id       = next_id + 8'd1;
   endtask

   // Advance one clock and update the reference model from the spec's rules.
   task automatic tick();
      bit   p, po;
      ent_t e;
      p  = valid_i && m_ready();
      po = m_vvalid() && vec_ready_i;
      e  = '{insn: insn_i, id: insn_id_i, sc: scalar_reg_i, ctx: vec_context_i};
      @(posedge clk_i);
      if (rst_i) begin
         mq.delete(); m_out = 0; m_under = 0;
      end else begin
         if (flush_i) mq.delete();
         else begin
            if (po) void'(mq.pop_front());
            if (p) mq.push_back(e);
         end
         if (vec_done_i && m_out == 0 && !po) m_under = 1;
         else m_out = m_out + int'(po) - int'(vec_done_i);
      end
      @(negedge clk_i);
   endtask

   task automatic test_reset();
      idle(); rst_i = 1'b1; tick(); rst_i = 1'b0; #1;
      n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", ready_o); end
      n_checks++; if (vec_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_vvalid got %b exp 0", vec_valid_o); end
      n_checks++; if (occupancy_o !== 3'd0 || outstanding_o !== 4'd0 || underflow_o !== 1'b0) begin
         n_fail++; $display("FAIL reset_counts got occ=%0d out=%0d und=%b exp 0/0/0", occupancy_o, outstanding_o, underflow_o); end
      n_checks++; if (vec_insn_o !== 32'd0 || vec_insn_id_o !== 8'd0) begin
         n_fail++; $display("FAIL reset_payload got insn=%h id=%h exp 0", vec_insn_o, vec_insn_id_o); end
   endtask

   task automatic test_fill_drain();
      logic [IDW-1:0] first;
      idle(); first = next_id;
      for (int i = 0; i < DEPTH; i++) begin
         valid_i = 1'b1; new_payload(); #1;
         n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL fill_ready[%0d] got %b exp 1", i, ready_o); end
         if (i == 0) begin
            n_checks++; if (vec_valid_o !== 1'b0) begin n_fail++; $display("FAIL no_bypass got %b exp 0", vec_valid_o); end
         end
         tick();
      end
      valid_i = 1'b1; new_payload(); #1;
      n_checks++; if (ready_o !== 1'b0 || occupancy_o !== 3'd4) begin
         n_fail++; $display("FAIL full got ready=%b occ=%0d exp 0/4", ready_o, occupancy_o); end
      valid_i = 1'b0; vec_ready_i = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         #1;
         n_checks++; if (vec_valid_o !== 1'b1 || vec_insn_id_o !== first + IDW'(i)) begin
            n_fail++; $display("FAIL drain[%0d] got v=%b id=%0d exp 1/%0d", i, vec_valid_o, vec_insn_id_o, first + IDW'(i)); end
         tick();
      end
      #1;
      n_checks++; if (occupancy_o !== 3'd0 || vec_valid_o !== 1'b0 || outstanding_o !== 4'd4) begin
         n_fail++; $display("FAIL drained got occ=%0d v=%b out=%0d exp 0/0/4", occupancy_o, vec_valid_o, outstanding_o); end
      idle(); vec_done_i = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      idle();
   endtask

   task automatic test_push_pop();
      logic [IDW-1:0] exp_id;
      idle(); exp_id = next_id;
      for (int i = 0; i < 2; i++) begin valid_i = 1'b1; new_payload(); tick(); end
      valid_i = 1'b1; vec_ready_i = 1'b1; vec_done_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         new_payload(); #1;
         n_checks++; if (vec_valid_o !== 1'b1 || vec_insn_id_o !== exp_id) begin
            n_fail++; $display("FAIL pp_id[%0d] got v=%b id=%0d exp 1/%0d", i, vec_valid_o, vec_insn_id_o, exp_id); end
         exp_id = exp_id + 8'd1;
         tick();
         n_checks++; if (occupancy_o !== 3'd2 || outstanding_o !== 4'd0) begin
            n_fail++; $display("FAIL pp_occ[%0d] got occ=%0d out=%0d exp 2/0", i, occupancy_o, outstanding_o); end
      end
      valid_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         n_checks++; if (vec_insn_id_o !== exp_id || vec_insn_o !== mq[0].insn || vec_context_o !== mq[0].ctx) begin
            n_fail++; $display("FAIL pp_tail[%0d] got id=%0d exp %0d", i, vec_insn_id_o, exp_id); end
         exp_id = exp_id + 8'd1;
         tick();
      end
      idle();
   endtask

   task automatic test_throttle_flush();
      idle(); valid_i = 1'b1; vec_ready_i = 1'b1;
      for (int i = 0; i < 20; i++) begin
         new_payload(); #1;
         n_checks++; if (vec_valid_o !== m_vvalid()) begin
            n_fail++; $display("FAIL thr_v[%0d] got %b exp %b", i, vec_valid_o, m_vvalid()); end
         tick();
      end
      valid_i = 1'b0; #1;
      n_checks++; if (outstanding_o !== 4'd8 || vec_valid_o !== 1'b0 || occupancy_o !== 3'd4) begin
         n_fail++; $display("FAIL throttled got out=%0d v=%b occ=%0d exp 8/0/4", outstanding_o, vec_valid_o, occupancy_o); end
      vec_done_i = 1'b1; tick(); vec_done_i = 1'b0; #1;
      n_checks++; if (vec_valid_o !== 1'b1) begin n_fail++; $display("FAIL thr_release got %b exp 1", vec_valid_o); end
      tick(); #1;
      n_checks++; if (vec_valid_o !== 1'b0 || outstanding_o !== 4'd8 || occupancy_o !== 3'd3) begin
         n_fail++; $display("FAIL thr_one got v=%b out=%0d occ=%0d exp 0/8/3", vec_valid_o, outstanding_o, occupancy_o); end
      vec_ready_i = 1'b0; vec_done_i = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      vec_done_i = 1'b0; flush_i = 1'b1; valid_i = 1'b1; vec_ready_i = 1'b1; new_payload(); #1;
      n_checks++; if (ready_o !== 1'b0 || vec_valid_o !== 1'b0) begin
         n_fail++; $display("FAIL flush_block got ready=%b v=%b exp 0/0", ready_o, vec_valid_o); end
      tick(); idle(); #1;
      n_checks++; if (occupancy_o !== 3'd0 || outstanding_o !== 4'd2) begin
         n_fail++; $display("FAIL flush got occ=%0d out=%0d exp 0/2", occupancy_o, outstanding_o); end
      flush_i = 1'b1; vec_done_i = 1'b1; tick(); idle(); #1;
      n_checks++; if (outstanding_o !== 4'd1) begin n_fail++; $display("FAIL flush_done got %0d exp 1", outstanding_o); end
      vec_done_i = 1'b1; tick(); idle();
   endtask

   task automatic test_underflow();
      idle(); vec_done_i = 1'b1; tick(); idle(); #1;
      n_checks++; if (underflow_o !== 1'b1 || outstanding_o !== 4'd0) begin
         n_fail++; $display("FAIL underflow got und=%b out=%0d exp 1/0", underflow_o, outstanding_o); end
      rst_i = 1'b1; tick(); rst_i = 1'b0;
      valid_i = 1'b1; new_payload(); tick(); valid_i = 1'b0;
      vec_ready_i = 1'b1; vec_done_i = 1'b1; tick(); idle(); #1;
      n_checks++; if (underflow_o !== 1'b0 || outstanding_o !== 4'd0 || occupancy_o !== 3'd0) begin
         n_fail++; $display("FAIL done_with_pop got und=%b out=%0d occ=%0d exp 0/0/0", underflow_o, outstanding_o, occupancy_o); end
   endtask

   task automatic test_reset_mid();
      idle(); valid_i = 1'b1; vec_ready_i = 1'b1;
      for (int i = 0; i < 40 && m_out < 5; i++) begin
         vec_ready_i = (m_out < 4) || (mq.size() != 0 && m_out == 4) ? 1'b1 : 1'b0;
         new_payload(); tick();
      end
      vec_ready_i = 1'b0;
      for (int i = 0; i < 10 && mq.size() < 3; i++) begin new_payload(); tick(); end
      valid_i = 1'b0; #1;
      n_checks++; if (occupancy_o !== 3'd3 || outstanding_o !== 4'd5) begin
         n_fail++; $display("FAIL pre_reset got occ=%0d out=%0d exp 3/5", occupancy_o, outstanding_o); end
      rst_i = 1'b1; tick(); rst_i = 1'b0; #1;
      n_checks++; if (occupancy_o !== 3'd0 || outstanding_o !== 4'd0 || ready_o !== 1'b1 || vec_valid_o !== 1'b0) begin
         n_fail++; $display("FAIL mid_reset got occ=%0d out=%0d rdy=%b v=%b exp 0/0/1/0", occupancy_o, outstanding_o, ready_o, vec_valid_o); end
   endtask

   task automatic test_random();
      idle();
      for (int i = 0; i < 400; i++) begin
         rst_i       = ($urandom_range(63) == 0);
         flush_i     = ($urandom_range(15) == 0);
         valid_i     = ($urandom_range(2) != 0);
         vec_ready_i = ($urandom_range(2) != 0);
         vec_done_i  = ($urandom_range(3) == 0);
         new_payload(); #1;
         n_checks++; if (ready_o !== m_ready() || vec_valid_o !== m_vvalid()) begin
            n_fail++; $display("FAIL rnd_hs[%0d] got rdy=%b v=%b exp %b/%b", i, ready_o, vec_valid_o, m_ready(), m_vvalid()); end
         if (m_vvalid()) begin
            n_checks++; if (vec_insn_o !== mq[0].insn || vec_insn_id_o !== mq[0].id ||
                            vec_scalar_reg_o !== mq[0].sc || vec_context_o !== mq[0].ctx) begin
               n_fail++; $display("FAIL rnd_payload[%0d] got id=%0d insn=%h exp %0d/%h", i, vec_insn_id_o, vec_insn_o, mq[0].id, mq[0].insn); end
         end
         n_checks++; if (occupancy_o !== 3'(mq.size()) || outstanding_o !== 4'(m_out) || underflow_o !== m_under) begin
            n_fail++; $display("FAIL rnd_state[%0d] got occ=%0d out=%0d und=%b exp %0d/%0d/%b", i, occupancy_o, outstanding_o, underflow_o, mq.size(), m_out, m_under); end
         tick();
      end
      idle();
   endtask

   initial begin
      idle(); new_payload();
      @(negedge clk_i);
      test_reset();
      test_fill_drain();
      test_push_pop();
      test_throttle_flush();
      test_underflow();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
